// File: rtl/burst_memory.sv
// Word-organised main memory answering single-word and fixed-length burst accesses.
// Words are stored big-endian, and read data comes back one registered word per clock.
module burst_memory #(
  parameter int                       data_width    = 32,
  parameter int                       address_width = 32,
  parameter int                       depth         = 1048576,
  parameter logic [address_width-1:0] start_addr    = 32'h80020000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [address_width-1:0] address,
  input  logic [data_width-1:0]    data_in,
  input  logic [1:0]               access_size,
  input  logic                     rw,
  input  logic                     enable,
  output logic                     busy,
  output logic [data_width-1:0]    data_out
);

  localparam int words = depth / 4;
  localparam int idx_w = $clog2(words);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                   state;
  logic [address_width-1:0] beat_addr;
  logic [3:0]               cnt;
  logic                     rw_q;

  logic                     cur_act;
  logic                     cur_rw;
  logic                     cur_ok;
  logic [address_width-1:0] cur_addr;
  logic [address_width-1:0] offset;
  logic [idx_w-1:0]         cur_idx;

  // Each element is one word with its lowest-addressed byte in the MSBs (big-endian).
  logic [data_width-1:0] mem [words];

  function automatic logic [4:0] beats_for(input logic [1:0] size);
    case (size)
      2'b00:   return 5'd1;
      2'b01:   return 5'd4;
      2'b10:   return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

  function automatic logic addr_ok(input logic [address_width-1:0] a);
    logic [address_width-1:0] off;
    off = a - start_addr;
    return (a >= start_addr) && (off <= address_width'(depth - 4));
  endfunction

  // An accept beat uses the live request inputs; a burst beat uses the latched state.
  always_comb begin
    cur_act  = 1'b0;
    cur_rw   = rw_q;
    cur_addr = beat_addr;
    if (state == BURST) begin
      cur_act = 1'b1;
    end else if (enable) begin
      cur_act  = 1'b1;
      cur_rw   = rw;
      cur_addr = address & ~address_width'(3);
    end
    offset  = cur_addr - start_addr;
    cur_idx = idx_w'(offset >> 2);
    cur_ok  = addr_ok(cur_addr);
  end

  // Storage is never reset. Out-of-range write beats are dropped.
  always_ff @(posedge clock) begin
    if (reset_n && cur_act && !cur_rw && cur_ok)
      mem[cur_idx] <= data_in;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      data_out  <= '0;
      cnt       <= '0;
      beat_addr <= '0;
      rw_q      <= 1'b0;
    end else begin
      if (cur_act && cur_rw)
        data_out <= cur_ok ? mem[cur_idx] : '0;
      case (state)
        IDLE: begin
          if (enable && (beats_for(access_size) != 5'd1)) begin
            state     <= BURST;
            busy      <= 1'b1;
            cnt       <= 4'(beats_for(access_size) - 5'd1);
            beat_addr <= cur_addr + address_width'(4);
            rw_q      <= rw;
          end
        end
        BURST: begin
          beat_addr <= beat_addr + address_width'(4);
          cnt       <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_memory.sv
// Scoreboard bench for burst_memory: a word model predicts reads, and the per-beat
// expected data is queued before each read burst and popped as the beats come back.
module tb_burst_memory;

  localparam logic [31:0] START = 32'h80020000;
  localparam int          DEPTH = 1048576;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic [1:0]  access_size = '0;
  logic        rw = 1'b1;
  logic        enable = 1'b0;
  logic        busy;
  logic [31:0] data_out;

  burst_memory dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .address     (address),
    .data_in     (data_in),
    .access_size (access_size),
    .rw          (rw),
    .enable      (enable),
    .busy        (busy),
    .data_out    (data_out)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] wbuf  [16];
  logic [31:0] obs_d [16];
  logic        obs_b [16];
  logic [31:0] model [logic [31:0]];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] off;
    off = a - START;
    return (a >= START) && (off <= 32'(DEPTH - 4));
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    if (!in_rng(a)) return 32'h0;
    if (!model.exists(a)) return 32'hxxxxxxxx;
    return model[a];
  endfunction

  function automatic int beats(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 4 : (sz == 2'd2) ? 8 : 16;
  endfunction

  // Drives one complete access. Writes update the model. Outputs are captured 1 ns after each edge.
  task automatic burst(input logic [31:0] addr, input logic [1:0] sz, input logic r,
                       input bit noise);
    int          n;
    logic [31:0] a;
    n = beats(sz);
    a = addr & ~32'h3;
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        enable = 1'b1; address = addr; access_size = sz; rw = r;
      end else if (noise) begin
        enable = 1'($urandom); rw = 1'($urandom);
        address = $urandom; access_size = 2'($urandom);
      end else begin
        enable = 1'b0;
      end
      data_in = r ? $urandom : wbuf[k];
      if (!r && in_rng(a)) model[a] = wbuf[k];
      @(posedge clock); #1;
      obs_d[k] = data_out;
      obs_b[k] = busy;
      a = a + 32'd4;
    end
    enable = 1'b0;
    rw = 1'b1;
  endtask

  task automatic queue_reads(input logic [31:0] addr, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(exp_word((addr & ~32'h3) + 32'(4 * k)));
  endtask

  task automatic test_reset;
    reset_n = 1'b0; enable = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data_out); end
    reset_n = 1'b1;
    last_rd = 32'h0;
  endtask

  task automatic test_single;
    logic [31:0] exp;
    wbuf[0] = 32'h27BDFFE8;
    burst(START, 2'd0, 1'b0, 1'b0);
    checks++;
    if (obs_b[0] !== 1'b0) begin errors++; $display("FAIL single_wr_busy: got %b want 0", obs_b[0]); end
    checks++;
    if (obs_d[0] !== last_rd) begin errors++; $display("FAIL single_wr_hold: got %h want %h", obs_d[0], last_rd); end
    queue_reads(START, 1);
    burst(START, 2'd0, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (obs_d[0] !== exp) begin errors++; $display("FAIL single_rd: got %h want %h", obs_d[0], exp); end
    checks++;
    if (obs_d[0][31:24] !== 8'h27) begin errors++; $display("FAIL single_byte0: got %h want 27", obs_d[0][31:24]); end
    checks++;
    if (obs_b[0] !== 1'b0) begin errors++; $display("FAIL single_rd_busy: got %b want 0", obs_b[0]); end
    last_rd = exp;
    @(posedge clock); #1;
    checks++;
    if (data_out !== last_rd) begin errors++; $display("FAIL idle_hold: got %h want %h", data_out, last_rd); end
  endtask

  task automatic test_reset_survive;
    logic [31:0] exp;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL rst2_data: got %h want 0", data_out); end
    reset_n = 1'b1;
    queue_reads(START, 1);
    burst(START, 2'd0, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (obs_d[0] !== exp) begin errors++; $display("FAIL rst2_survive: got %h want %h", obs_d[0], exp); end
    last_rd = exp;
  endtask

  task automatic test_burst4;
    logic [31:0] exp;
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222;
    wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
    burst(START + 32'h10, 2'd1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_b[k] !== (k < 3)) begin errors++; $display("FAIL b4_wr_busy[%0d]: got %b want %b", k, obs_b[k], k < 3); end
      checks++;
      if (obs_d[k] !== last_rd) begin errors++; $display("FAIL b4_wr_hold[%0d]: got %h want %h", k, obs_d[k], last_rd); end
    end
    queue_reads(START + 32'h10, 4);
    burst(START + 32'h10, 2'd1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      exp = exp_q.pop_front();
      checks++;
      if (obs_d[k] !== exp) begin errors++; $display("FAIL b4_rd[%0d]: got %h want %h", k, obs_d[k], exp); end
      checks++;
      if (obs_b[k] !== (k < 3)) begin errors++; $display("FAIL b4_rd_busy[%0d]: got %b want %b", k, obs_b[k], k < 3); end
    end
    last_rd = exp;
  endtask

  task automatic test_burst16_noise;
    logic [31:0] exp;
    int          hi;
    for (int k = 0; k < 16; k++) wbuf[k] = $urandom | 32'h1;
    burst(START + 32'h100, 2'd3, 1'b0, 1'b1);
    queue_reads(START + 32'h100, 16);
    burst(START + 32'h100, 2'd3, 1'b1, 1'b1);
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      exp = exp_q.pop_front();
      checks++;
      if (obs_d[k] !== exp) begin errors++; $display("FAIL b16_rd[%0d]: got %h want %h", k, obs_d[k], exp); end
      if (obs_b[k] === 1'b1) hi++;
    end
    checks++;
    if (hi != 15 || obs_b[15] !== 1'b0) begin
      errors++; $display("FAIL b16_busy: got %0d high cycles (last %b) want 15 (last 0)", hi, obs_b[15]);
    end
    last_rd = exp;
  endtask

  task automatic test_out_of_range;
    logic [31:0] exp;
    logic [31:0] top;
    top = START + 32'(DEPTH);
    wbuf[0] = 32'hDEADBEEF;
    burst(32'h80000000, 2'd0, 1'b0, 1'b0);
    burst(top, 2'd0, 1'b0, 1'b0);
    queue_reads(START, 1);
    queue_reads(32'h80000000, 1);
    queue_reads(START, 1);
    queue_reads(top, 1);
    burst(START, 2'd0, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (obs_d[0] !== exp) begin errors++; $display("FAIL oor_pre1: got %h want %h", obs_d[0], exp); end
    burst(32'h80000000, 2'd0, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (obs_d[0] !== exp) begin errors++; $display("FAIL oor_low: got %h want %h", obs_d[0], exp); end
    burst(START, 2'd0, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (obs_d[0] !== exp) begin errors++; $display("FAIL oor_pre2: got %h want %h", obs_d[0], exp); end
    burst(top, 2'd0, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (obs_d[0] !== exp) begin errors++; $display("FAIL oor_top: got %h want %h", obs_d[0], exp); end
    wbuf[0] = 32'hA0A0A0A0; wbuf[1] = 32'hB1B1B1B1;
    wbuf[2] = 32'hC2C2C2C2; wbuf[3] = 32'hD3D3D3D3;
    burst(top - 32'd8, 2'd1, 1'b0, 1'b0);
    queue_reads(top - 32'd8, 4);
    burst(top - 32'd8, 2'd1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      exp = exp_q.pop_front();
      checks++;
      if (obs_d[k] !== exp) begin errors++; $display("FAIL oor_cross[%0d]: got %h want %h", k, obs_d[k], exp); end
    end
    last_rd = exp;
  endtask

  task automatic test_reset_mid_burst;
    logic [31:0] base;
    logic [31:0] nw [3];
    logic [31:0] exp;
    base = START + 32'h200;
    for (int k = 0; k < 8; k++) wbuf[k] = 32'h5A000000 + 32'(k);
    burst(base, 2'd2, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) nw[k] = 32'hC0DE0000 + 32'(k);
    for (int k = 0; k < 3; k++) begin
      enable = (k == 0); address = base; access_size = 2'd2; rw = 1'b0;
      data_in = nw[k];
      model[base + 32'(4 * k)] = nw[k];
      @(posedge clock); #1;
    end
    reset_n = 1'b0; enable = 1'b0; data_in = 32'hBAD0BAD0;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h want 0", data_out); end
    reset_n = 1'b1;
    queue_reads(base, 1);
    enable = 1'b1; address = base; access_size = 2'd0; rw = 1'b1;
    @(posedge clock); #1;
    enable = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (data_out !== exp) begin errors++; $display("FAIL midrst_first_rd: got %h want %h", data_out, exp); end
    queue_reads(base, 8);
    burst(base, 2'd2, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      exp = exp_q.pop_front();
      checks++;
      if (obs_d[k] !== exp) begin errors++; $display("FAIL midrst_rd[%0d]: got %h want %h", k, obs_d[k], exp); end
    end
    last_rd = exp;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp;
    wbuf[0] = 32'h0BADCAFE;
    burst(START + 32'h40, 2'd0, 1'b0, 1'b0);
    queue_reads(START + 32'h10, 4);
    queue_reads(START + 32'h40, 1);
    burst(START + 32'h10, 2'd1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      exp = exp_q.pop_front();
      checks++;
      if (obs_d[k] !== exp) begin errors++; $display("FAIL b2b_burst[%0d]: got %h want %h", k, obs_d[k], exp); end
    end
    burst(START + 32'h40, 2'd0, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (obs_d[0] !== exp) begin errors++; $display("FAIL b2b_single: got %h want %h", obs_d[0], exp); end
    last_rd = exp;
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_survive();
    test_burst4();
    test_burst16_noise();
    test_out_of_range();
    test_reset_mid_burst();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_memory.md
# burst_memory

Word-organised main-memory responder that services the instruction/data loader and the processor fetch/load-store path. It accepts single-word or fixed-length burst accesses over the enable/rw/access_size/busy interface, stores words big-endian, and returns read data one word per clock. It is the slave end of the interface driven by the program loader and the pipeline's memory stage.

## Interface
- data_width, 32: word width in bits
- address_width, 32: byte-address width
- depth, 1048576: storage size in bytes (multiple of 4)
- start_addr, 32'h80020000: byte address mapped to storage offset 0

- clock  in  1  single clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- address  in  address_width  byte address of first beat; bits [1:0] ignored
- data_in  in  data_width  write data, one word per beat
- access_size  in  2  00=1 word, 01=4 words, 10=8 words, 11=16 words
- rw  in  1  0=write, 1=read
- enable  in  1  request; sampled only when idle
- busy  out  1  high while a burst is in progress after its first beat
- data_out  out  data_width  read data, registered

## Operation
- States: IDLE, BURST. Registers: beat address (word-aligned), remaining count cnt (4 bits), latched rw.
- Beat count N from access_size: 1/4/8/16.
- IDLE, edge with enable=1 = accept edge E0: beat 0 performed at E0 using address & ~3.
  - N=1: stay IDLE.
  - N>1: go BURST, cnt=N-1, beat address = (address & ~3)+4, rw latched.
- BURST, each edge: perform one beat at beat address, beat address += 4, cnt -= 1; cnt reaching 0 -> IDLE.
- During BURST, address/access_size/rw/enable inputs are ignored; bursts cannot be stalled or aborted except by reset.
- Write beat: store data_in at offset = beat address - start_addr, bytes big-endian (bits [31:24] at lowest offset). data_out unchanged.
- Read beat: data_out <= word at offset, big-endian assembly.
- Out of range (beat address < start_addr or offset+3 >= depth): write dropped, read returns 32'h0. Applies per beat; a burst crossing the top continues counting with dropped/zero beats. Address arithmetic is modulo 2^32.
- Storage contents are not initialised and not cleared by reset.

## Timing
- Reset (reset_n=0 at an edge): state IDLE, busy=0, data_out=0, cnt=0; storage unaffected. Reset mid-burst aborts; beats already written remain, remaining beats never occur.
- busy = (state==BURST): low after E0 for N=1; high after E0 through E(N-2), low after E(N-1). Total busy-high cycles = N-1.
- Write burst: initiator presents word k on data_in for edge Ek, k=0..N-1.
- Read latency 1: word k visible on data_out after Ek; last word appears in the cycle busy falls.
- Back-to-back: a new request may be accepted at the first edge where state is IDLE (edge after busy falls, or any edge after a single access).
- data_out holds its last value through writes and idle cycles.
- enable=1 while busy is not queued; the initiator must re-present it once busy=0.

## Test plan
- Reset: hold reset_n=0 two cycles -> busy=0, data_out=0; release, read 0x80020000 of previously written location -> original data survives reset.
- Single write 0x80020000 <- 0x27BDFFE8 then single read -> data_out=0x27BDFFE8 one edge after read accept, busy never high; byte offset 0 holds 0x27.
- Write burst access_size=01 at 0x80020010, data 0x11111111..0x44444444 -> busy high 3 cycles; read burst 01 -> data_out 0x11111111,0x22222222,0x33333333,0x44444444 on consecutive edges, busy falls with last word.
- 16-beat read burst while toggling enable/rw/address mid-burst -> inputs ignored, 16 consecutive words from start address, busy high exactly 15 cycles.
- Out of range: write 0xDEADBEEF at 0x80000000 and at start_addr+depth, read both -> 0x0; 4-beat write at start_addr+depth-8 -> first two beats stored, last two dropped, read returns them and 0,0.
- Reset asserted after beat 2 of an 8-beat write -> beats 0-2 stored, beats 3-7 unchanged, busy=0 and data_out=0 next cycle, immediate new single read accepted.
